pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised inter-stage pipeline register with valid/ready flow control. Replaces fixed
//  per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
//  It carries an opaque DATA_W payload (packed category/opcode/operands/we/addrs). It has an
//  optional 2-entry skid buffer that breaks the ready path, plus flush, a global rdy_in
//  freeze and bubble insertion.
// PARAMETERS
//  DATA_W   128  payload width in bits (>=1)
//  SKID     1    1: 2-entry skid buffer, registered up_ready; 0: single reg, combinational ready
//  BUBBLE   0    DATA_W-bit value driven on dn_data when no valid entry (encodes IC_EMP/INS_EMP)
// PORTS
//  clk_in     in   1       clock, rising edge
//  rst_in     in   1       asynchronous, active-high reset
//  rdy_in     in   1       global enable; 0 freezes all state, no transfers either side
//  flush_in   in   1       synchronous kill of all held entries (branch mispredict / exception)
//  up_valid   in   1       upstream stage presents payload
//  up_ready   out  1       block accepts payload this cycle
//  up_data    in   DATA_W  upstream payload
//  dn_valid   out  1       payload on dn_data is valid
//  dn_ready   in   1       downstream stage consumes payload this cycle
//  dn_data    out  DATA_W  payload to downstream; BUBBLE when dn_valid=0
//  busy_out   out  1       1 when block cannot accept (SKID state, or SKID=0 and stalled full)
// BEHAVIOUR
//  Transfers:
//   - up_xfer = up_valid & up_ready.
//   - dn_xfer = dn_valid & dn_ready.
//   - Both are meaningful only on a clk_in rising edge.
//  Reset (async, rst_in=1):
//   - State goes to EMPTY; main_q and skid_q go to BUBBLE.
//   - Outputs: dn_valid=0, dn_data=BUBBLE, up_ready=0, busy_out=0.
//   - up_ready rises after reset release, with rdy_in=1.
//  States (SKID=1): EMPTY (main invalid), FULL (main valid, skid empty), SKID (both valid).
//   EMPTY: up_xfer -> FULL, main<=up_data.
//   FULL:
//    - up_xfer & dn_xfer -> FULL, main<=up_data.
//    - up_xfer & !dn_xfer -> SKID, skid<=up_data.
//    - !up_xfer & dn_xfer -> EMPTY, main<=BUBBLE.
//    - Otherwise hold.
//   SKID:
//    - up_ready=0.
//    - dn_xfer -> FULL, main<=skid, skid<=BUBBLE.
//    - Otherwise hold.
//  SKID=0: only EMPTY/FULL exist; up_ready=rdy_in & (!main_valid | dn_ready).
//  up_ready (SKID=1) = rdy_in & (state!=SKID); no combinational path from dn_ready.
//  dn_valid = rdy_in & main_valid; dn_data = main_q (BUBBLE when invalid, never stale payload).
//  busy_out:
//   - SKID=1: busy_out = (state==SKID), decoded from the state register.
//   - SKID=0: busy_out = main_valid & !dn_ready.
//  Ordering: strict FIFO; skid entry is always older than any newly accepted entry; no loss, no dup.
//  Latency: 1 cycle up_xfer -> dn_valid when EMPTY; throughput 1/cycle when dn_ready=1.
//  flush_in=1 at an edge:
//   - Highest priority, and overrides rdy_in.
//   - Next state is EMPTY; main and skid go to BUBBLE.
//   - A same-cycle up_xfer is discarded.
//   - up_ready is not forced low during flush (upstream flushes in the same cycle).
//  rdy_in=0:
//   - up_ready=0 and dn_valid=0, so no handshakes occur.
//   - State and payload regs hold their values; dn_data still shows main_q.
//  Reset mid-operation: held entries are lost, with no partial-cycle glitch required beyond async clear.
// TESTING
//  1. Reset, then rdy_in=1, up_valid=1, data=0x11, dn_ready=1:
//     -> next cycle dn_valid=1, dn_data=0x11; steady 1/cycle stream 0x11,0x12,0x13.
//  2. FULL(0x21), dn_ready=0, push 0x22 (SKID=1):
//     -> state SKID, up_ready=0, busy_out=1.
//     -> dn_ready=1 yields 0x21 then 0x22, in order.
//  3. SKID state, flush_in=1 with up_valid=1 data=0x33:
//     -> next cycle dn_valid=0, dn_data=BUBBLE, up_ready=1.
//     -> 0x33 never appears downstream.
//  4. FULL(0x44), rdy_in=0 for 3 cycles with dn_ready=1, up_valid=1:
//     -> dn_valid=0, up_ready=0, no transfer.
//     -> rdy_in=1 -> 0x44 delivered once.
//  5. SKID=0 build, FULL(0x55), dn_ready toggles 0/1 each cycle, upstream always valid:
//     -> up_ready equals dn_ready same cycle; no drop or duplication over 16 items.
//  6. Assert rst_in async mid-cycle in SKID state:
//     -> dn_valid=0, dn_data=BUBBLE, busy_out=0 before the next clk_in edge.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//  Reusable inter-stage pipeline register with valid/ready flow control.
//  The payload is opaque; the block only moves it. With SKID=1 a second
//  entry absorbs the one extra beat accepted while downstream stalls. This
//  keeps up_ready a pure function of registered state (plus the global
//  rdy_in), so it has no combinational path from dn_ready.
//
//  Parameters
//    DATA_W  payload width in bits
//    SKID    1: two entries, registered up_ready
//            0: one entry, up_ready follows dn_ready combinationally
//    BUBBLE  value shown on dn_data when nothing valid is held
//
//  Ports
//    clk_in    clock, rising edge
//    rst_in    asynchronous active-high reset
//    rdy_in    global enable; 0 freezes state and blocks both handshakes
//    flush_in  synchronous kill of all held entries (beats rdy_in)
//    up_valid  upstream presents up_data
//    up_ready  block accepts up_data this cycle
//    up_data   upstream payload
//    dn_valid  dn_data carries a valid payload
//    dn_ready  downstream consumes dn_data this cycle
//    dn_data   payload to downstream, BUBBLE when not valid
//    busy_out  block cannot accept a new beat
module pipe_stage_buf #(
  parameter int                 DATA_W = 128,
  parameter int                 SKID   = 1,
  parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic              busy_out
);

  localparam bit USE_SKID = (SKID != 0);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              main_valid;
  logic              up_xfer;
  logic              dn_xfer;

  assign main_valid = (state_q != ST_EMPTY);

  // up_ready is held low while rst_in is asserted, so upstream sees no
  // acceptance until reset has been released.
  generate
    if (USE_SKID) begin : g_skid
      assign up_ready = !rst_in && rdy_in && (state_q != ST_SKID);
      assign busy_out = (state_q == ST_SKID);
    end else begin : g_noskid
      assign up_ready = !rst_in && rdy_in && (!main_valid || dn_ready);
      assign busy_out = main_valid && !dn_ready;
    end
  endgenerate

  assign dn_valid = rdy_in && main_valid;
  assign dn_data  = main_q;

  assign up_xfer = up_valid && up_ready;
  assign dn_xfer = dn_valid && dn_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_in) begin
      // Flush wins over everything, including a same-cycle up_xfer.
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            state_d = ST_FULL;
            main_d  = up_data;
          end
        end
        ST_FULL: begin
          if (up_xfer && dn_xfer) begin
            main_d = up_data;
          end else if (up_xfer && USE_SKID) begin
            // The new beat is younger than main, so it parks in skid.
            state_d = ST_SKID;
            skid_d  = up_data;
          end else if (dn_xfer) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end
        end
        ST_SKID: begin
          if (dn_xfer) begin
            state_d = ST_FULL;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // Stage boundary: state and payload registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf. One instance uses SKID=1 and a second
// instance uses SKID=0. Both use an 8-bit payload and a non-zero BUBBLE.
module tb_pipe_stage_buf;

  localparam logic [7:0] BUB = 8'hEE;

  logic       clk;
  logic       rst;
  // SKID=1 instance
  logic       rdy, flush, uv, ur, dv, dr, busy;
  logic [7:0] ud, dd;
  // SKID=0 instance
  logic       rdy0, flush0, uv0, ur0, dv0, dr0, busy0;
  logic [7:0] ud0, dd0;

  int total;
  int passed;

  pipe_stage_buf #(.DATA_W(8), .SKID(1), .BUBBLE(BUB)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .up_valid(uv), .up_ready(ur), .up_data(ud),
    .dn_valid(dv), .dn_ready(dr), .dn_data(dd), .busy_out(busy)
  );

  pipe_stage_buf #(.DATA_W(8), .SKID(0), .BUBBLE(BUB)) dut0 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy0), .flush_in(flush0),
    .up_valid(uv0), .up_ready(ur0), .up_data(ud0),
    .dn_valid(dv0), .dn_ready(dr0), .dn_data(dd0), .busy_out(busy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int rcvd;
    total = 0;
    passed = 0;
    rst = 1'b1;
    rdy = 1'b1; flush = 1'b0; uv = 1'b0; ud = 8'h00; dr = 1'b0;
    rdy0 = 1'b1; flush0 = 1'b0; uv0 = 1'b0; ud0 = 8'h00; dr0 = 1'b0;

    // Reset state
    #2;
    chk("rst_dv", dv, 0);
    chk("rst_dd", dd, BUB);
    chk("rst_ur", ur, 0);
    chk("rst_busy", busy, 0);
    chk("rst0_dv", dv0, 0);
    chk("rst0_ur", ur0, 0);
    #10;
    rst = 1'b0;
    #1;
    chk("rel_ur", ur, 1);
    chk("rel0_ur", ur0, 1);

    // 1: streaming at one beat per cycle
    uv = 1'b1; ud = 8'h11; dr = 1'b1;
    tick();
    chk("t1_dv_a", dv, 1);
    chk("t1_dd_a", dd, 8'h11);
    ud = 8'h12;
    tick();
    chk("t1_dd_b", dd, 8'h12);
    ud = 8'h13;
    tick();
    chk("t1_dd_c", dd, 8'h13);
    chk("t1_dv_c", dv, 1);
    uv = 1'b0;
    tick();
    chk("t1_dv_end", dv, 0);
    chk("t1_dd_end", dd, BUB);

    // 2: skid fill, then ordered drain
    uv = 1'b1; ud = 8'h21; dr = 1'b0;
    tick();
    ud = 8'h22;
    tick();
    chk("t2_ur", ur, 0);
    chk("t2_busy", busy, 1);
    chk("t2_dd_a", dd, 8'h21);
    uv = 1'b0; dr = 1'b1;
    tick();
    chk("t2_dd_b", dd, 8'h22);
    chk("t2_dv_b", dv, 1);
    chk("t2_busy_b", busy, 0);
    tick();
    chk("t2_dv_end", dv, 0);

    // 3: flush in SKID state discards held and incoming beats
    uv = 1'b1; ud = 8'h31; dr = 1'b0;
    tick();
    ud = 8'h32;
    tick();
    chk("t3_busy", busy, 1);
    flush = 1'b1; ud = 8'h33;
    tick();
    flush = 1'b0; uv = 1'b0;
    #1;
    chk("t3_dv", dv, 0);
    chk("t3_dd", dd, BUB);
    chk("t3_ur", ur, 1);
    dr = 1'b1;
    tick();
    chk("t3_dv_after", dv, 0);
    chk("t3_dd_after", dd, BUB);

    // 4: rdy_in freeze
    uv = 1'b1; ud = 8'h44; dr = 1'b0;
    tick();
    rdy = 1'b0; dr = 1'b1; ud = 8'h45;
    #1;
    chk("t4_dv", dv, 0);
    chk("t4_ur", ur, 0);
    chk("t4_dd", dd, 8'h44);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_dv_frz", dv, 0);
      chk("t4_dd_frz", dd, 8'h44);
    end
    rdy = 1'b1; uv = 1'b0;
    #1;
    chk("t4_dv_go", dv, 1);
    chk("t4_dd_go", dd, 8'h44);
    tick();
    chk("t4_dv_once", dv, 0);

    // 6: asynchronous reset mid-cycle in SKID state
    uv = 1'b1; ud = 8'h61; dr = 1'b0;
    tick();
    ud = 8'h62;
    tick();
    uv = 1'b0;
    chk("t6_busy_pre", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_dv", dv, 0);
    chk("t6_dd", dd, BUB);
    chk("t6_busy", busy, 0);
    chk("t6_ur", ur, 0);
    #2;
    rst = 1'b0;
    tick();
    chk("t6_ur_rel", ur, 1);
    chk("t6_dv_rel", dv, 0);

    // 5: SKID=0, dn_ready toggling, upstream always valid
    uv0 = 1'b1; ud0 = 8'h55; dr0 = 1'b0;
    tick();
    sent = 1;
    rcvd = 0;
    for (int i = 0; i < 64 && rcvd < 16; i++) begin
      dr0 = i[0];
      ud0 = 8'(8'h55 + sent);
      #1;
      chk("t5_ur", ur0, dr0);
      chk("t5_busy", busy0, !dr0);
      if (dv0 && dr0) begin
        chk("t5_dd", dd0, 8'(8'h55 + rcvd));
        rcvd++;
      end
      if (uv0 && ur0) sent++;
      tick();
    end
    chk("t5_count", rcvd, 16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
